// File: rtl/change_monitor_pkg.sv
// change_monitor_pkg: shared types and defaults for the change monitor.
// Holds the entry layout, default widths and the pointer-width helper.
package change_monitor_pkg;

    localparam int DATA_W_DEF = 6;
    localparam int TS_W_DEF   = 16;
    localparam int DEPTH_DEF  = 8;

    // Width of a FIFO index; the FIFO pointers carry one extra wrap bit.
    function automatic int ptr_w(input int depth);
        return $clog2(depth);
    endfunction

    localparam int PTR_W = $clog2(DEPTH_DEF);

    // Layout of one recorded event at the default widths.
    typedef struct packed {
        logic [TS_W_DEF-1:0]   ts;
        logic [DATA_W_DEF-1:0] data;
    } entry_t;

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with registered storage and occupancy count.
// Ports: clk, rst (sync, high), wr_en/wr_data, rd_en/rd_data, full, empty, count.
module sync_fifo
    import change_monitor_pkg::*;
#(
    parameter int WIDTH = 22,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = ptr_w(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW:0]      wr_ptr;
    logic [PW:0]      rd_ptr;
    logic             do_wr;
    logic             do_rd;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[PW] != rd_ptr[PW]) &&
                   (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);

    // A read in the same cycle frees the slot the write is about to use.
    assign do_rd = rd_en && !empty;
    assign do_wr = wr_en && (!full || do_rd);

    assign count   = wr_ptr - rd_ptr;
    assign rd_data = mem[rd_ptr[PW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_wr) begin
                mem[wr_ptr[PW-1:0]] <= wr_data;
                wr_ptr <= wr_ptr + (PW+1)'(1);
            end
            if (do_rd) begin
                rd_ptr <= rd_ptr + (PW+1)'(1);
            end
        end
    end

endmodule

// File: rtl/change_monitor.sv
// change_monitor: records {ts, sample} into a FIFO whenever the sample changes.
// Ports: clk, rst, en, sample_in, out_valid/out_ready/out_ts/out_data, count, overflow.
module change_monitor
    import change_monitor_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int TS_W   = TS_W_DEF,
    parameter int DEPTH  = DEPTH_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    input  logic [DATA_W-1:0]      sample_in,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [TS_W-1:0]        out_ts,
    output logic [DATA_W-1:0]      out_data,
    output logic [$clog2(DEPTH):0] count,
    output logic                   overflow
);

    typedef struct packed {
        logic [TS_W-1:0]   ts;
        logic [DATA_W-1:0] data;
    } slot_t;

    localparam int SLOT_W = $bits(slot_t);

    logic [TS_W-1:0]   ts;
    logic [DATA_W-1:0] last;
    logic              primed;
    logic              evt;
    logic              pop;
    logic              full;
    logic              empty;
    slot_t             wr_slot;
    slot_t             rd_slot;
    logic [SLOT_W-1:0] rd_vec;

    // The first enabled edge always logs, mirroring the time-0 monitor line.
    assign evt = en && (!primed || (sample_in != last));
    assign pop = !empty && out_ready;

    assign wr_slot = '{ts: ts, data: sample_in};
    assign rd_slot = slot_t'(rd_vec);

    assign out_valid = !empty;
    assign out_ts    = rd_slot.ts;
    assign out_data  = rd_slot.data;

    always_ff @(posedge clk) begin
        if (rst) begin
            ts       <= '0;
            last     <= '0;
            primed   <= 1'b0;
            overflow <= 1'b0;
        end else begin
            if (en) begin
                ts     <= ts + TS_W'(1);
                last   <= sample_in;
                primed <= 1'b1;
            end
            if (evt && full && !pop) begin
                overflow <= 1'b1;
            end
        end
    end

    sync_fifo #(
        .WIDTH (SLOT_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (evt),
        .wr_data (wr_slot),
        .rd_en   (out_ready),
        .rd_data (rd_vec),
        .full    (full),
        .empty   (empty),
        .count   (count)
    );

endmodule

// File: tb/tb_change_monitor.sv
// tb_change_monitor: directed scoreboard bench for change_monitor.
// Expected entries are queued at drive time and compared as they are popped.
module tb_change_monitor;
    import change_monitor_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [5:0]  sample_in;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_ts;
    logic [5:0]  out_data;
    logic [3:0]  count;
    logic        overflow;

    int     checks = 0;
    int     errors = 0;
    entry_t sb[$];

    change_monitor dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .sample_in (sample_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_ts    (out_ts),
        .out_data  (out_data),
        .count     (count),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // A pop happens at the next rising edge; compare the head now.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            checks++;
            assert (sb.size() != 0) else begin
                errors++;
                $error("FAIL unexpected_entry: observed ts=%0d data=%b expected none",
                       out_ts, out_data);
            end
            if (sb.size() != 0) begin
                entry_t e;
                e = sb.pop_front();
                checks++;
                assert (out_ts === e.ts && out_data === e.data) else begin
                    errors++;
                    $error("FAIL entry: observed ts=%0d data=%b expected ts=%0d data=%b",
                           out_ts, out_data, e.ts, e.data);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic expect_entry(input int t, input logic [5:0] d);
        entry_t e;
        e.ts   = 16'(t);
        e.data = d;
        sb.push_back(e);
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        en        = 1'b0;
        out_ready = 1'b0;
        sample_in = '0;
        sb.delete();
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic idle_drain(input string tag);
        en        = 1'b0;
        out_ready = 1'b1;
        repeat (10) tick();
        chk({tag, "_count"}, 32'(count), 32'd0);
        chk({tag, "_sb_left"}, 32'(sb.size()), 32'd0);
    endtask

    initial begin
        logic [5:0] s;
        logic [5:0] prev;

        // Reset state
        do_reset();
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_ts", 32'(out_ts), 32'd0);
        chk("rst_data", 32'(out_data), 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_overflow", 32'(overflow), 32'd0);

        // Fork-join pattern
        prev = '0;
        for (int c = 0; c < 25; c++) begin
            s = (c >= 20) ? 6'b010110 : (c >= 10) ? 6'b010100 :
                (c >= 5) ? 6'b010000 : 6'b000000;
            if (c == 0 || s != prev) expect_entry(c, s);
            prev      = s;
            en        = 1'b1;
            out_ready = 1'b1;
            sample_in = s;
            tick();
        end
        idle_drain("forkjoin");

        // Begin-end pattern
        do_reset();
        prev = '0;
        for (int c = 0; c < 40; c++) begin
            s = (c >= 35) ? 6'b010110 : (c >= 15) ? 6'b010100 :
                (c >= 5) ? 6'b010000 : 6'b000000;
            if (c == 0 || s != prev) expect_entry(c, s);
            prev      = s;
            en        = 1'b1;
            out_ready = 1'b1;
            sample_in = s;
            tick();
        end
        idle_drain("beginend");

        // Overflow: 10 changing samples, only 8 fit
        do_reset();
        for (int c = 0; c < 10; c++) begin
            if (c < 8) expect_entry(c, 6'(c));
            en        = 1'b1;
            sample_in = 6'(c);
            tick();
        end
        en = 1'b0;
        chk("ovf_count", 32'(count), 32'd8);
        chk("ovf_flag", 32'(overflow), 32'd1);
        chk("ovf_valid", 32'(out_valid), 32'd1);
        idle_drain("ovf_drain");
        chk("ovf_sticky", 32'(overflow), 32'd1);

        // Full FIFO with a pop in the same cycle as a change
        do_reset();
        chk("rst_clears_ovf", 32'(overflow), 32'd0);
        for (int c = 0; c < 8; c++) begin
            expect_entry(c, 6'(c));
            en        = 1'b1;
            sample_in = 6'(c);
            tick();
        end
        chk("full_count", 32'(count), 32'd8);
        expect_entry(8, 6'd8);
        sample_in = 6'd8;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        en        = 1'b0;
        chk("fullpop_count", 32'(count), 32'd8);
        chk("fullpop_ovf", 32'(overflow), 32'd0);
        idle_drain("fullpop_drain");

        // Enable gating: change while disabled reported at frozen ts
        do_reset();
        expect_entry(0, 6'b000000);
        for (int c = 0; c < 4; c++) begin
            en        = 1'b1;
            out_ready = 1'b1;
            sample_in = '0;
            tick();
        end
        en        = 1'b0;
        sample_in = 6'h2A;
        repeat (3) tick();
        expect_entry(4, 6'h2A);
        en = 1'b1;
        repeat (4) tick();
        idle_drain("gate");

        // Reset with five entries queued
        do_reset();
        for (int c = 0; c < 5; c++) begin
            en        = 1'b1;
            sample_in = 6'(c + 1);
            tick();
        end
        chk("mid_count_before", 32'(count), 32'd5);
        rst = 1'b1;
        sb.delete();
        tick();
        chk("mid_count", 32'(count), 32'd0);
        chk("mid_valid", 32'(out_valid), 32'd0);
        chk("mid_overflow", 32'(overflow), 32'd0);
        rst = 1'b0;
        expect_entry(0, 6'h15);
        en        = 1'b1;
        out_ready = 1'b1;
        sample_in = 6'h15;
        repeat (4) tick();
        idle_drain("mid_restart");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
